// File: rtl/mrd_pkg.sv
// Shared types and defaults for the mixed-radix DFT memory sink path.
// Provides the sink FSM state type, default widths and the bank one-hot helper.
package mrd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SINK  = 2'd1,
        FLUSH = 2'd2
    } mrd_sink_st_t;

    localparam int MRD_wCNT      = 12;
    localparam int MRD_wADDR     = 8;
    localparam int MRD_NBANK_MAX = 32;

    // Bank index k maps to write-enable bit nbank-1-k (bank 0 is the MSB).
    function automatic logic [MRD_NBANK_MAX-1:0] onehot_msb(input int unsigned idx,
                                                            input int unsigned nbank);
        if (idx < nbank) begin
            return {{(MRD_NBANK_MAX-1){1'b0}}, 1'b1} << (nbank - 1 - idx);
        end
        return '0;
    endfunction

endpackage

// File: rtl/mrd_bank_rr.sv
// Round-robin bank index and shared bank address counter.
// idx steps 0..modulus-1; addr advances when idx wraps. addr_wrap is sticky once the
// address counter has rolled over past its maximum, and is cleared with clr.
module mrd_bank_rr
    import mrd_pkg::*;
#(
    parameter int NBANK = 7,
    parameter int wADDR = MRD_wADDR,
    parameter int wNB   = $clog2(NBANK + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    input  logic [wNB-1:0]   modulus,
    output logic [wNB-1:0]   idx,
    output logic [wADDR-1:0] addr,
    output logic             addr_wrap
);

    logic [wNB-1:0]   idx_reg, idx_next;
    logic [wADDR-1:0] addr_reg, addr_next;
    logic             wrap_reg, wrap_next;
    logic             idx_last;

    assign idx_last = (idx_reg == modulus - wNB'(1));

    // Next index/address: clear has priority over advance.
    always_comb begin
        idx_next  = idx_reg;
        addr_next = addr_reg;
        wrap_next = wrap_reg;
        if (clr) begin
            idx_next  = '0;
            addr_next = '0;
            wrap_next = 1'b0;
        end else if (adv) begin
            if (idx_last) begin
                idx_next  = '0;
                addr_next = addr_reg + wADDR'(1);
                if (addr_reg == '1) begin
                    wrap_next = 1'b1;
                end
            end else begin
                idx_next = idx_reg + wNB'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg  <= '0;
            addr_reg <= '0;
            wrap_reg <= 1'b0;
        end else begin
            idx_reg  <= idx_next;
            addr_reg <= addr_next;
            wrap_reg <= wrap_next;
        end
    end

    assign idx       = idx_reg;
    assign addr      = addr_reg;
    assign addr_wrap = wrap_reg;

endmodule

// File: rtl/mrd_sink_wrgen.sv
// Sink-side RAM write generator: spreads one frame of samples round-robin over the
// active banks with a common bank address, flags trigger point and frame end, and
// reports frames that stop short.
// Optional feature macro: MRD_SINK_OVF_CHK_EN (address overflow detection with FLUSH);
// when undefined the address wraps and err_overrun is tied low.
module mrd_sink_wrgen
    import mrd_pkg::*;
#(
    parameter int NBANK = 7,
    parameter int wADDR = MRD_wADDR,
    parameter int wDATA = 36,
    parameter int wCNT  = MRD_wCNT,
    localparam int wNB  = $clog2(NBANK + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [wNB-1:0]   cfg_nbank,
    input  logic [wCNT-1:0]  cfg_len,
    input  logic [wCNT-1:0]  cfg_trig,
    input  logic             in_valid,
    input  logic [wDATA-1:0] in_data,
    output logic [wADDR-1:0] wr_addr,
    output logic [NBANK-1:0] wr_en,
    output logic [wDATA-1:0] wr_data,
    output logic             trig_pulse,
    output logic             frame_done,
    output logic             busy,
    output logic             err_underrun,
    output logic             err_overrun
);

    mrd_sink_st_t     state_reg, state_next;
    logic [wCNT:0]    cnt_reg, cnt_next, cnt_inc;
    logic [wCNT:0]    len_reg, len_next, len_in_eff;
    logic [wCNT-1:0]  trig_cfg_reg, trig_cfg_next;
    logic [wNB-1:0]   nbank_reg, nbank_next, nb_in_eff, bank_mod;

    logic [NBANK-1:0] wr_en_reg, wr_en_next;
    logic [wADDR-1:0] wr_addr_reg, wr_addr_next;
    logic [wDATA-1:0] wr_data_reg, wr_data_next;
    logic             trig_reg, trig_next;
    logic             done_reg, done_next;
    logic             unr_reg, unr_next;
    logic             ovr_reg, ovr_next;

    logic             bank_clr, bank_adv, bank_wrap;
    logic [wNB-1:0]   bank_idx;
    logic [wADDR-1:0] bank_addr;
    logic [NBANK-1:0] bank_oh;

    // Out-of-range bank counts fall back to all banks; length 0 means 2^wCNT.
    assign nb_in_eff  = (cfg_nbank == '0 || cfg_nbank > wNB'(NBANK)) ? wNB'(NBANK) : cfg_nbank;
    assign len_in_eff = (cfg_len == '0) ? {1'b1, {wCNT{1'b0}}} : {1'b0, cfg_len};
    assign cnt_inc    = cnt_reg + (wCNT+1)'(1);
    // The first sample of a frame must advance with the bank count being latched.
    assign bank_mod   = (state_reg == IDLE) ? nb_in_eff : nbank_reg;
    assign bank_oh    = NBANK'(onehot_msb(32'(bank_idx), NBANK));

    mrd_bank_rr #(
        .NBANK (NBANK),
        .wADDR (wADDR),
        .wNB   (wNB)
    ) u_bank_rr (
        .clk       (clk),
        .rst       (rst),
        .clr       (bank_clr),
        .adv       (bank_adv),
        .modulus   (bank_mod),
        .idx       (bank_idx),
        .addr      (bank_addr),
        .addr_wrap (bank_wrap)
    );

`ifndef MRD_SINK_OVF_CHK_EN
    logic unused_wrap;
    assign unused_wrap = bank_wrap;
`endif

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        nbank_next    = nbank_reg;
        len_next      = len_reg;
        trig_cfg_next = trig_cfg_reg;
        bank_clr      = 1'b0;
        bank_adv      = 1'b0;
        wr_en_next    = '0;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        trig_next     = 1'b0;
        done_next     = 1'b0;
        unr_next      = 1'b0;
        ovr_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    nbank_next    = nb_in_eff;
                    len_next      = len_in_eff;
                    trig_cfg_next = cfg_trig;
                    wr_en_next    = bank_oh;
                    wr_addr_next  = bank_addr;
                    wr_data_next  = in_data;
                    trig_next     = (cfg_trig == wCNT'(1));
                    if (len_in_eff == (wCNT+1)'(1)) begin
                        done_next = 1'b1;
                        bank_clr  = 1'b1;
                    end else begin
                        bank_adv   = 1'b1;
                        cnt_next   = (wCNT+1)'(1);
                        state_next = SINK;
                    end
                end
            end
            SINK: begin
                if (in_valid) begin
`ifdef MRD_SINK_OVF_CHK_EN
                    if (bank_wrap) begin
                        ovr_next   = 1'b1;
                        bank_clr   = 1'b1;
                        cnt_next   = '0;
                        state_next = FLUSH;
                    end else
`endif
                    begin
                        wr_en_next   = bank_oh;
                        wr_addr_next = bank_addr;
                        wr_data_next = in_data;
                        trig_next    = (trig_cfg_reg != '0) && ({1'b0, trig_cfg_reg} == cnt_inc);
                        if (cnt_inc == len_reg) begin
                            done_next  = 1'b1;
                            bank_clr   = 1'b1;
                            cnt_next   = '0;
                            state_next = IDLE;
                        end else begin
                            bank_adv = 1'b1;
                            cnt_next = cnt_inc;
                        end
                    end
                end else begin
                    unr_next   = 1'b1;
                    bank_clr   = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
`ifdef MRD_SINK_OVF_CHK_EN
            FLUSH: begin
                if (!in_valid) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // State, latched configuration and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            nbank_reg    <= '0;
            len_reg      <= '0;
            trig_cfg_reg <= '0;
            wr_en_reg    <= '0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            trig_reg     <= 1'b0;
            done_reg     <= 1'b0;
            unr_reg      <= 1'b0;
            ovr_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            nbank_reg    <= nbank_next;
            len_reg      <= len_next;
            trig_cfg_reg <= trig_cfg_next;
            wr_en_reg    <= wr_en_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            trig_reg     <= trig_next;
            done_reg     <= done_next;
            unr_reg      <= unr_next;
            ovr_reg      <= ovr_next;
        end
    end

    assign wr_en        = wr_en_reg;
    assign wr_addr      = wr_addr_reg;
    assign wr_data      = wr_data_reg;
    assign trig_pulse   = trig_reg;
    assign frame_done   = done_reg;
    assign busy         = (state_reg != IDLE);
    assign err_underrun = unr_reg;
`ifdef MRD_SINK_OVF_CHK_EN
    assign err_overrun  = ovr_reg;
`else
    assign err_overrun  = 1'b0;
    logic unused_ovr;
    assign unused_ovr = ovr_reg;
`endif

endmodule

// File: tb/tb_mrd_sink_wrgen.sv
// Testbench for mrd_sink_wrgen. Two instances share the input stream: a default one
// (wADDR=8) and a small-address one (wADDR=2) used for the address overflow scenario.
// Expected writes are queued when samples are driven and checked as writes appear.
module tb_mrd_sink_wrgen;

    localparam int NB  = 7;
    localparam int WD  = 36;
    localparam int WC  = 12;
    localparam int NBW = $clog2(NB + 1);
    localparam logic [NB-1:0] BANK0_EN = {1'b1, {(NB-1){1'b0}}};

    logic           clk = 1'b0;
    logic           rst;
    logic [NBW-1:0] cfg_nbank;
    logic [WC-1:0]  cfg_len;
    logic [WC-1:0]  cfg_trig;
    logic           in_valid;
    logic [WD-1:0]  in_data;

    logic [7:0]     a_wr_addr;
    logic [NB-1:0]  a_wr_en;
    logic [WD-1:0]  a_wr_data;
    logic           a_trig, a_done, a_busy, a_unr, a_ovr;
    logic [1:0]     b_wr_addr;
    logic [NB-1:0]  b_wr_en;
    logic [WD-1:0]  b_wr_data;
    logic           b_trig, b_done, b_busy, b_unr, b_ovr;

    mrd_sink_wrgen #(.NBANK(NB), .wADDR(8), .wDATA(WD), .wCNT(WC)) dut (
        .clk(clk), .rst(rst), .cfg_nbank(cfg_nbank), .cfg_len(cfg_len), .cfg_trig(cfg_trig),
        .in_valid(in_valid), .in_data(in_data), .wr_addr(a_wr_addr), .wr_en(a_wr_en),
        .wr_data(a_wr_data), .trig_pulse(a_trig), .frame_done(a_done), .busy(a_busy),
        .err_underrun(a_unr), .err_overrun(a_ovr)
    );

    mrd_sink_wrgen #(.NBANK(NB), .wADDR(2), .wDATA(WD), .wCNT(WC)) dut_small (
        .clk(clk), .rst(rst), .cfg_nbank(cfg_nbank), .cfg_len(cfg_len), .cfg_trig(cfg_trig),
        .in_valid(in_valid), .in_data(in_data), .wr_addr(b_wr_addr), .wr_en(b_wr_en),
        .wr_data(b_wr_data), .trig_pulse(b_trig), .frame_done(b_done), .busy(b_busy),
        .err_underrun(b_unr), .err_overrun(b_ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] en;
        logic [7:0]    addr;
        logic [WD-1:0] data;
        logic          trig;
        logic          done;
    } exp_t;

    exp_t exp_q[$];
    int   done_cyc[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   last_wr_cyc = 0;
    int   unr_cnt = 0;
    int   unr_cyc = 0;
    int   ovr_cnt = 0;
    int   ovr_cyc = 0;
    logic sel = 1'b0;

    logic [NB-1:0] m_en;
    logic [7:0]    m_addr;
    logic [WD-1:0] m_data;
    logic          m_trig, m_done, m_unr, m_ovr;
    exp_t          m_exp;

    // Scoreboard: every write of the selected instance is matched against the queue head.
    always @(negedge clk) begin
        cyc    = cyc + 1;
        m_en   = sel ? b_wr_en : a_wr_en;
        m_addr = sel ? {6'b0, b_wr_addr} : a_wr_addr;
        m_data = sel ? b_wr_data : a_wr_data;
        m_trig = sel ? b_trig : a_trig;
        m_done = sel ? b_done : a_done;
        m_unr  = sel ? b_unr : a_unr;
        m_ovr  = sel ? b_ovr : a_ovr;
        if (m_unr) begin
            unr_cnt = unr_cnt + 1;
            unr_cyc = cyc;
        end
        if (m_ovr) begin
            ovr_cnt = ovr_cnt + 1;
            ovr_cyc = cyc;
        end
        if (m_done) done_cyc.push_back(cyc);
        if (m_en != '0) begin
            last_wr_cyc = cyc;
            n_tests = n_tests + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_write: got en=%b addr=%0d, need no write", m_en, m_addr);
            end else begin
                m_exp = exp_q.pop_front();
                if (m_en !== m_exp.en || m_addr !== m_exp.addr || m_data !== m_exp.data ||
                    m_trig !== m_exp.trig || m_done !== m_exp.done) begin
                    n_fail = n_fail + 1;
                    $display("FAIL write_cmp: got en=%b addr=%0d data=%h trig=%b done=%b, need en=%b addr=%0d data=%h trig=%b done=%b",
                             m_en, m_addr, m_data, m_trig, m_done,
                             m_exp.en, m_exp.addr, m_exp.data, m_exp.trig, m_exp.done);
                end else begin
                    $display("[TB] cyc %0d write en=%b addr=%0d trig=%b done=%b ok",
                             cyc, m_en, m_addr, m_trig, m_done);
                end
            end
        end else begin
            n_tests = n_tests + 1;
            if ({m_trig, m_done} !== 2'b00) begin
                n_fail = n_fail + 1;
                $display("FAIL stray_pulse: got trig=%b done=%b without write, need 0 0", m_trig, m_done);
            end
        end
    end

    task automatic step(input logic v, input logic [WD-1:0] d);
        @(posedge clk);
        #2;
        in_valid = v;
        in_data  = d;
    endtask

    // Drives n_send samples; the first n_write of them are expected to be written.
    task automatic run_frame(input int nb, input int len, input int trig,
                             input int n_send, input int n_write, input int amod);
        int nb_eff;
        int len_eff;
        logic [WD-1:0] d;
        exp_t e;
        nb_eff  = (nb == 0 || nb > NB) ? NB : nb;
        len_eff = (len == 0) ? (1 << WC) : len;
        cfg_nbank = NBW'(nb);
        cfg_len   = WC'(len);
        cfg_trig  = WC'(trig);
        for (int s = 0; s < n_send; s++) begin
            d = WD'({$urandom(), $urandom()});
            if (s < n_write) begin
                e.en   = BANK0_EN >> (s % nb_eff);
                e.addr = 8'((s / nb_eff) % amod);
                e.data = d;
                e.trig = (trig != 0) && (s + 1 == trig);
                e.done = (s + 1 == len_eff);
                exp_q.push_back(e);
            end
            step(1'b1, d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        cfg_nbank = '0; cfg_len = '0; cfg_trig = '0;
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if ({a_wr_en, a_wr_addr, a_wr_data, a_trig, a_done, a_busy, a_unr, a_ovr} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got en=%b addr=%0d busy=%b, need all 0", a_wr_en, a_wr_addr, a_busy);
        end
        n_tests++;
        if ({b_wr_en, b_wr_addr, b_wr_data, b_trig, b_done, b_busy, b_unr, b_ovr} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got en=%b addr=%0d busy=%b, need all 0", b_wr_en, b_wr_addr, b_busy);
        end
        rst = 1'b0;
        repeat (2) step(1'b0, '0);
    endtask

    task automatic test_drained(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d writes outstanding, need 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_basic();
        int d0;
        int u0;
        d0 = done_cyc.size();
        u0 = unr_cnt;
        run_frame(7, 21, 15, 21, 21, 256);
        n_tests++;
        if (a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_mid: got %b, need 1", a_busy);
        end
        step(1'b0, '0);
        n_tests++;
        if (a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_end: got %b, need 0", a_busy);
        end
        repeat (2) step(1'b0, '0);
        n_tests++;
        if (done_cyc.size() != d0 + 1 || unr_cnt != u0) begin
            n_fail++;
            $display("FAIL basic_pulses: got done=%0d unr=%0d, need done=1 unr=0",
                     done_cyc.size() - d0, unr_cnt - u0);
        end
        test_drained("basic");
    endtask

    task automatic test_nbank3();
        int d0;
        d0 = done_cyc.size();
        run_frame(3, 9, 0, 9, 9, 256);
        repeat (3) step(1'b0, '0);
        n_tests++;
        if (done_cyc.size() != d0 + 1) begin
            n_fail++;
            $display("FAIL nbank3_done: got %0d, need 1", done_cyc.size() - d0);
        end
        test_drained("nbank3");
    endtask

    task automatic test_boundary();
        // nbank 0 behaves as all banks; trigger on the last sample coincides with done.
        run_frame(0, 8, 8, 8, 8, 256);
        repeat (2) step(1'b0, '0);
        // Single-sample frame: done and trig with the only write, never busy.
        run_frame(5, 1, 1, 1, 1, 256);
        step(1'b0, '0);
        n_tests++;
        if (a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL len1_busy: got %b, need 0", a_busy);
        end
        repeat (2) step(1'b0, '0);
        test_drained("boundary");
    endtask

    task automatic test_underrun();
        int d0;
        int u0;
        d0 = done_cyc.size();
        u0 = unr_cnt;
        run_frame(7, 21, 0, 10, 10, 256);
        repeat (3) step(1'b0, '0);
        n_tests++;
        if (unr_cnt != u0 + 1) begin
            n_fail++;
            $display("FAIL underrun_count: got %0d, need 1", unr_cnt - u0);
        end
        n_tests++;
        if (unr_cyc != last_wr_cyc + 1) begin
            n_fail++;
            $display("FAIL underrun_timing: got %0d cycles after last write, need 1", unr_cyc - last_wr_cyc);
        end
        n_tests++;
        if (done_cyc.size() != d0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun_state: got done=%0d busy=%b, need done=0 busy=0",
                     done_cyc.size() - d0, a_busy);
        end
        run_frame(7, 7, 0, 7, 7, 256);
        repeat (2) step(1'b0, '0);
        test_drained("underrun");
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cyc.size();
        run_frame(7, 14, 0, 14, 14, 256);
        run_frame(7, 14, 5, 14, 14, 256);
        repeat (2) step(1'b0, '0);
        n_tests++;
        if (done_cyc.size() != d0 + 2) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d, need 2", done_cyc.size() - d0);
        end else begin
            n_tests++;
            if (done_cyc[d0 + 1] - done_cyc[d0] != 14) begin
                n_fail++;
                $display("FAIL b2b_done_spacing: got %0d, need 14", done_cyc[d0 + 1] - done_cyc[d0]);
            end
        end
        test_drained("b2b");
    endtask

    task automatic test_overflow();
        int d0;
        int o0;
        int u0;
        sel = 1'b1;
        d0 = done_cyc.size();
        o0 = ovr_cnt;
        u0 = unr_cnt;
`ifdef MRD_SINK_OVF_CHK_EN
        run_frame(2, 12, 0, 12, 8, 4);
        n_tests++;
        if (b_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flush_busy: got %b, need 1", b_busy);
        end
        repeat (2) step(1'b0, '0);
        n_tests++;
        if (ovr_cnt != o0 + 1 || ovr_cyc != last_wr_cyc + 1) begin
            n_fail++;
            $display("FAIL ovf_pulse: got count=%0d offset=%0d, need count=1 offset=1",
                     ovr_cnt - o0, ovr_cyc - last_wr_cyc);
        end
        n_tests++;
        if (unr_cnt != u0 || done_cyc.size() != d0 || b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_exit: got unr=%0d done=%0d busy=%b, need 0 0 0",
                     unr_cnt - u0, done_cyc.size() - d0, b_busy);
        end
        run_frame(2, 4, 0, 4, 4, 4);
        repeat (2) step(1'b0, '0);
`else
        run_frame(2, 12, 0, 12, 12, 4);
        repeat (2) step(1'b0, '0);
        n_tests++;
        if (ovr_cnt != o0 || done_cyc.size() != d0 + 1) begin
            n_fail++;
            $display("FAIL ovf_wrap: got ovr=%0d done=%0d, need ovr=0 done=1",
                     ovr_cnt - o0, done_cyc.size() - d0);
        end
`endif
        test_drained("ovf");
        sel = 1'b0;
    endtask

    task automatic test_async_reset();
        int u0;
        int d0;
        u0 = unr_cnt;
        d0 = done_cyc.size();
        run_frame(7, 21, 0, 5, 5, 256);
        @(posedge clk);
        #7;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        n_tests++;
        if ({a_wr_en, a_wr_addr, a_wr_data, a_trig, a_done, a_busy, a_unr} !== '0) begin
            n_fail++;
            $display("FAIL arst_outputs: got en=%b addr=%0d busy=%b, need all 0", a_wr_en, a_wr_addr, a_busy);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) step(1'b0, '0);
        n_tests++;
        if (unr_cnt != u0 || done_cyc.size() != d0) begin
            n_fail++;
            $display("FAIL arst_pulses: got unr=%0d done=%0d, need 0 0", unr_cnt - u0, done_cyc.size() - d0);
        end
        run_frame(7, 3, 2, 3, 3, 256);
        repeat (2) step(1'b0, '0);
        test_drained("arst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nbank3();
        test_boundary();
        test_underrun();
        test_back_to_back();
        test_overflow();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
